// File: rtl/inst_mem_loader_if.sv
// Handshake/bus bundle between a program source, the fetch stage and inst_mem_loader.
// checksum_o exists only when LOAD_CHECKSUM_EN is defined.
interface inst_mem_loader_if #(
    parameter int CNT_W = 8
);
    logic             start_i;
    logic [31:0]      base_addr_i;
    logic [CNT_W-1:0] word_count_i;
    logic             in_valid_i;
    logic [7:0]       in_byte_i;
    logic             in_ready_o;
    logic [31:0]      fetch_addr_i;
    logic [31:0]      fetch_data_o;
    logic             load_busy_o;
    logic             load_done_o;
    logic             load_err_o;
`ifdef LOAD_CHECKSUM_EN
    logic [31:0]      checksum_o;

    modport master (
        output start_i, base_addr_i, word_count_i, in_valid_i, in_byte_i, fetch_addr_i,
        input  in_ready_o, fetch_data_o, load_busy_o, load_done_o, load_err_o, checksum_o
    );
    modport slave (
        input  start_i, base_addr_i, word_count_i, in_valid_i, in_byte_i, fetch_addr_i,
        output in_ready_o, fetch_data_o, load_busy_o, load_done_o, load_err_o, checksum_o
    );
`else
    modport master (
        output start_i, base_addr_i, word_count_i, in_valid_i, in_byte_i, fetch_addr_i,
        input  in_ready_o, fetch_data_o, load_busy_o, load_done_o, load_err_o
    );
    modport slave (
        input  start_i, base_addr_i, word_count_i, in_valid_i, in_byte_i, fetch_addr_i,
        output in_ready_o, fetch_data_o, load_busy_o, load_done_o, load_err_o
    );
`endif
endinterface

// File: rtl/inst_mem_loader.sv
// Packs a byte stream big-endian into a byte-addressed instruction memory read by fetch.
// Optional LOAD_CHECKSUM_EN adds an XOR-of-words checksum of the loaded program.
module inst_mem_loader #(
    parameter int MEM_BYTES = 128,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    inst_mem_loader_if.slave bus
);
    localparam int          AW        = $clog2(MEM_BYTES);
    localparam int          TW        = CNT_W + 2;
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   base_q, base_d;
    logic [TW-1:0] total_q, total_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [7:0]    mem_q [MEM_BYTES];
    logic          wr_en;
    logic [31:0]   wr_addr;
    logic [7:0]    rd_byte [4];
`ifdef LOAD_CHECKSUM_EN
    logic [23:0]   pend_q, pend_d;
    logic [31:0]   csum_q, csum_d;
`endif

    // Address wraps at 32 bits before the range check.
    assign wr_addr = base_q + 32'(cnt_q);

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        total_d          = total_q;
        cnt_d            = cnt_q;
        err_d            = err_q;
        wr_en            = 1'b0;
        bus.in_ready_o   = 1'b0;
        bus.load_busy_o  = 1'b0;
        bus.load_done_o  = 1'b0;
`ifdef LOAD_CHECKSUM_EN
        pend_d           = pend_q;
        csum_d           = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    err_d = 1'b0;
`ifdef LOAD_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (bus.base_addr_i[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (bus.word_count_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        base_d  = bus.base_addr_i;
                        total_d = {bus.word_count_i, 2'b00};
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                bus.in_ready_o  = 1'b1;
                bus.load_busy_o = 1'b1;
                if (bus.in_valid_i) begin
                    // Out-of-range bytes are dropped but still consume a slot.
                    if (wr_addr < MEM_LIMIT) wr_en = 1'b1;
                    else                     err_d = 1'b1;
                    cnt_d = cnt_q + TW'(1);
`ifdef LOAD_CHECKSUM_EN
                    pend_d = {pend_q[15:0], bus.in_byte_i};
                    if (cnt_q[1:0] == 2'b11) csum_d = csum_q ^ {pend_q, bus.in_byte_i};
`endif
                    if (cnt_q == total_q - TW'(1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                bus.load_done_o = 1'b1;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            total_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            pend_q  <= '0;
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef LOAD_CHECKSUM_EN
            pend_q  <= pend_d;
            csum_q  <= csum_d;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_BYTES; i++) mem_q[i] <= 8'h00;
        end else if (wr_en) begin
            mem_q[wr_addr[AW-1:0]] <= bus.in_byte_i;
        end
    end

    // Unaligned fetch: each of the four bytes is range-checked on its own.
    for (genvar k = 0; k < 4; k++) begin : g_rd
        logic [31:0] a;
        assign a          = bus.fetch_addr_i + 32'(k);
        assign rd_byte[k] = (a < MEM_LIMIT) ? mem_q[a[AW-1:0]] : 8'h00;
    end

    assign bus.fetch_data_o = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
    assign bus.load_err_o   = err_q;
`ifdef LOAD_CHECKSUM_EN
    assign bus.checksum_o   = csum_q;
`endif
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed + randomized bench for inst_mem_loader against a byte-array reference model.
module tb_inst_mem_loader;
    localparam int MEM_BYTES = 128;
    localparam int CNT_W     = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_mem_loader_if #(.CNT_W(CNT_W)) bus ();
    inst_mem_loader #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  mm [MEM_BYTES];
    logic        m_err;
    logic [31:0] m_csum;
    logic [7:0]  fixed_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_fetch(input logic [31:0] a);
        logic [31:0] r;
        logic [31:0] x;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            x = a + 32'(k);
            r = {r[23:0], (x < MEM_BYTES) ? mm[x[6:0]] : 8'h00};
        end
        return r;
    endfunction

    task automatic check_fetch(input string tag, input logic [31:0] a);
        bus.fetch_addr_i = a;
        #1;
        check(tag, bus.fetch_data_o, model_fetch(a));
    endtask

    task automatic model_clear();
        for (int i = 0; i < MEM_BYTES; i++) mm[i] = 8'h00;
        m_err  = 1'b0;
        m_csum = '0;
    endtask

    // mode: 0 = in_valid held high, 1 = one stall before every byte, 2 = random stalls
    task automatic do_load(input string tag, input logic [31:0] base, input int wc, input int mode);
        logic [7:0]  b;
        logic [31:0] a;
        logic [31:0] w;
        int          gap;
        w = '0;
        bus.start_i      = 1'b1;
        bus.base_addr_i  = base;
        bus.word_count_i = CNT_W'(wc);
        step();
        bus.start_i = 1'b0;
        m_err  = 1'b0;
        m_csum = '0;
        if (base[1:0] != 2'b00 || wc == 0) begin
            m_err = (base[1:0] != 2'b00);
        end else begin
            for (int i = 0; i < wc * 4; i++) begin
                gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) begin
                    bus.in_valid_i  = 1'b0;
                    bus.in_byte_i   = 8'($urandom);
                    bus.start_i     = 1'($urandom_range(0, 1));
                    bus.base_addr_i = 32'h0000_0002;
                    #1;
                    check({tag, "_stall_ready"}, bus.in_ready_o, 1);
                    check({tag, "_stall_busy"}, bus.load_busy_o, 1);
                    step();
                    bus.start_i = 1'b0;
                end
                b = (fixed_q.size() > i) ? fixed_q[i] : 8'($urandom);
                a = base + 32'(i);
                check_fetch({tag, "_prewrite"}, a);
                bus.in_valid_i = 1'b1;
                bus.in_byte_i  = b;
                check({tag, "_busy"}, bus.load_busy_o, 1);
                check({tag, "_done_early"}, bus.load_done_o, 0);
                step();
                bus.in_valid_i = 1'b0;
                if (a < MEM_BYTES) mm[a[6:0]] = b;
                else               m_err = 1'b1;
                w = {w[23:0], b};
                if (i % 4 == 3) m_csum = m_csum ^ w;
                check_fetch({tag, "_postwrite"}, a);
            end
        end
        check({tag, "_done"}, bus.load_done_o, 1);
        check({tag, "_done_busy"}, bus.load_busy_o, 0);
        check({tag, "_done_ready"}, bus.in_ready_o, 0);
        check({tag, "_err"}, bus.load_err_o, m_err);
`ifdef LOAD_CHECKSUM_EN
        check({tag, "_csum"}, bus.checksum_o, m_csum);
`endif
        step();
        check({tag, "_done_pulse"}, bus.load_done_o, 0);
        check({tag, "_err_sticky"}, bus.load_err_o, m_err);
    endtask

    initial begin
        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.base_addr_i  = '0;
        bus.word_count_i = '0;
        bus.in_valid_i   = 1'b0;
        bus.in_byte_i    = '0;
        bus.fetch_addr_i = '0;
        model_clear();
        step();
        step();
        check("rst_fetch0", bus.fetch_data_o, 32'h0000_0000);
        check("rst_ready", bus.in_ready_o, 0);
        check("rst_busy", bus.load_busy_o, 0);
        check("rst_done", bus.load_done_o, 0);
        check("rst_err", bus.load_err_o, 0);
`ifdef LOAD_CHECKSUM_EN
        check("rst_csum", bus.checksum_o, 32'h0);
`endif
        rst = 1'b0;
        step();

        fixed_q = '{8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h64, 8'h00, 8'h00};
        do_load("ld_solid", 32'h0, 2, 0);
        check_fetch("ld_solid_w0", 32'h0);
        check("ld_solid_w0k", bus.fetch_data_o, 32'h0022_0000);
        check_fetch("ld_solid_w1", 32'h4);
        check("ld_solid_w1k", bus.fetch_data_o, 32'h0064_0000);
`ifdef LOAD_CHECKSUM_EN
        check("ld_solid_csumk", bus.checksum_o, 32'h0046_0000);
`endif
        do_load("ld_toggle", 32'h0, 2, 1);
        check_fetch("ld_toggle_w0", 32'h0);
        check("ld_toggle_w0k", bus.fetch_data_o, 32'h0022_0000);
        fixed_q.delete();

        do_load("ld_edge", 32'h7C, 2, 2);
        check_fetch("ld_edge_7e", 32'h7E);
        check("ld_edge_errk", bus.load_err_o, 1);
        check_fetch("ld_edge_80", 32'h80);

        do_load("ld_misal", 32'h2, 1, 0);
        check_fetch("ld_misal_0", 32'h0);
        do_load("ld_zero", 32'h10, 0, 0);
        check("ld_zero_clrk", bus.load_err_o, 0);

        do_load("ld_wrap", 32'hFFFF_FFFC, 3, 2);
        check_fetch("ld_wrap_fe", 32'hFFFF_FFFE);
        check_fetch("ld_wrap_4", 32'h4);

        for (int it = 0; it < 10; it++) begin
            logic [31:0] rb;
            rb = {$urandom_range(0, 40), 2'b00};
            if ($urandom_range(0, 7) == 0) rb[1:0] = 2'($urandom_range(1, 3));
            do_load("ld_rand", rb, int'($urandom_range(0, 4)), 2);
            for (int j = 0; j < 4; j++) check_fetch("rd_rand", 32'($urandom_range(0, 135)));
        end
        for (int a = 0; a < MEM_BYTES; a += 4) check_fetch("sweep", 32'(a));

        // Reset in the middle of a load whose writes are all out of range.
        bus.start_i      = 1'b1;
        bus.base_addr_i  = 32'h80;
        bus.word_count_i = CNT_W'(2);
        step();
        bus.start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_byte_i  = 8'($urandom);
            step();
        end
        bus.in_valid_i = 1'b0;
        check("mid_err_before", bus.load_err_o, 1);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check("mid_busy", bus.load_busy_o, 0);
        check("mid_ready", bus.in_ready_o, 0);
        check("mid_err", bus.load_err_o, 0);
        check("mid_done", bus.load_done_o, 0);
        check_fetch("mid_fetch0", 32'h0);
        check_fetch("mid_fetch4", 32'h4);
        #2;
        rst = 1'b0;
        step();
        check("post_rst_busy", bus.load_busy_o, 0);
        do_load("ld_after_rst", 32'h8, 2, 2);
        check_fetch("ld_after_rst_8", 32'h8);
        check_fetch("ld_after_rst_0", 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Writer side of the instruction-fetch interface. Accepts a byte stream over a valid/ready handshake and packs it big-endian into a byte-addressed instruction memory. The fetch stage reads 32-bit words from the same memory combinationally through fetch_addr/fetch_data. While a program load is in progress, load_busy is asserted so the pipeline can use it as freeze.

Parameters:
MEM_BYTES, 128, instruction memory size in bytes; a multiple of 4.
CNT_W, 8, width of word_count; maximum load is 2^CNT_W-1 words.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous reset, active-high.
start  in  1  one-cycle request to begin a load; sampled only in IDLE.
base_addr  in  32  byte address of the first loaded word.
word_count  in  CNT_W  number of 32-bit words to load.
in_valid  in  1  in_byte holds a valid program byte.
in_byte  in  8  program byte; MSB-first within each word.
in_ready  out  1  loader can accept a byte this cycle.
fetch_addr  in  32  byte address from the fetch stage (PC).
fetch_data  out  32  {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
load_busy  out  1  load in progress; drive to the fetch freeze input.
load_done  out  1  one-cycle pulse when a load completes.
load_err  out  1  sticky error flag; cleared by rst or by an accepted start.
checksum  out  32  present only with LOAD_CHECKSUM_EN.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; all memory bytes = 0x00.
  - in_ready, load_busy, load_done, load_err = 0.
  - Byte counter = 0; checksum = 0.
- States: IDLE, LOAD, DONE.
- IDLE, start=1:
  - Accepting start clears load_err.
  - base_addr[1:0] != 0: load_err=1, load_done pulses next cycle via DONE, memory untouched.
  - word_count == 0: go to DONE, no writes.
  - Otherwise: latch base_addr; set total = word_count*4 (CNT_W+2 bits); set byte counter = 0; go to LOAD.
- LOAD:
  - in_ready = 1 and load_busy = 1.
  - A byte is accepted on a rising edge with in_valid && in_ready.
  - Accepted byte is written to mem[base + counter], then counter increments.
  - After the byte with counter == total-1 is accepted, go to DONE.
  - No timeout: in_valid low simply stalls.
- Out-of-range write: if base+counter >= MEM_BYTES, the write is dropped, load_err = 1, and the counter still advances. The load runs to completion.
- DONE: load_done = 1 for exactly one cycle; in_ready = 0; load_busy = 0; next state IDLE.
- start outside IDLE is ignored, with no effect on state or flags.
- Fetch read:
  - Purely combinational from the current memory contents.
  - Each byte with an index >= MEM_BYTES reads 0x00.
  - There is no alignment requirement on fetch_addr.
- Write/read collision: a byte written at an edge is visible on fetch_data after that edge. There is no bypass in the same cycle.
- Address arithmetic is 32-bit, unsigned, with wrap-around. Wrapped addresses are then range-checked as above.
- Reset mid-load: load aborts; memory is cleared, including bytes already written.

Optional Feature:
Macro LOAD_CHECKSUM_EN.
- When defined:
  - A 32-bit checksum register accumulates the XOR of every completed 32-bit word, assembled big-endian, whether or not its write was dropped.
  - The checksum clears on an accepted start and on rst.
  - The final value is valid from the load_done cycle until the next accepted start.
- When undefined: the checksum port and its logic are absent.

Test Plan:
- Reset, then fetch_addr=0 -> fetch_data=0x00000000, in_ready=0, load_busy=0.
- start, base=0, word_count=2, bytes 00 22 00 00 00 64 00 00 with in_valid held high -> load_busy=1 for 8 cycles, then load_done pulses. fetch_addr=0 gives 0x00220000 and fetch_addr=4 gives 0x00640000.
- Same load with in_valid toggling every other cycle -> identical memory contents. load_done arrives only after the 8th accepted byte, and in_ready stays 1 throughout LOAD.
- start with base=0x7C, word_count=2 (MEM_BYTES=128) -> first word written to 0x7C..0x7F, second word dropped. load_err=1 and load_done pulses. fetch_addr=0x7E gives {mem[7E], mem[7F], 00, 00}.
- start with base=0x02 -> no writes, load_err=1, load_done one cycle later. A second start with word_count=0 in IDLE clears load_err and pulses load_done.
- Assert rst after 3 bytes of a load -> state IDLE, fetch of address 0 reads 0, load_err=0. With LOAD_CHECKSUM_EN, a 2-word load of 0x00220000 and 0x00640000 gives checksum=0x00460000.
